// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the FIFO drain path.
// No logic; no latency.
// No flow control.
package fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int CNT_W          = 16;
    localparam int SKID_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        STALL  = 2'd2
    } rd_state_e;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry first-in first-out output buffer; head entry drives downstream data.
// A push becomes visible at the head one edge later; a pop removes the head at the edge.
// A push into a full buffer is dropped unless a pop happens on the same edge.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_vld,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop_rdy,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pop_fire;
    logic                  push_fire;

    assign pop_fire  = pop_rdy && (occ_q != 2'd0);
    assign push_fire = push_vld && ((occ_q != 2'd2) || pop_fire);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_fire, pop_fire})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_dat;
                else               tail_d = push_dat;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Same-edge push and pop: the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = push_dat;
                end else begin
                    head_d = tail_q;
                    tail_d = push_dat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_dat = head_q;
    assign occ      = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains an external FIFO into a 2-entry buffer and delivers words downstream with count and XOR checksum.
// fifo_read to out_valid is 2 cycles; one word per cycle sustained with out_ready held high.
// out_ready low holds out_data; reads stop once buffered plus inflight words fill the buffer.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = SKID_DEPTH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      rd_count,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [1:0] DEPTH_L = BUF_DEPTH[1:0];

    rd_state_e             state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_W-1:0]      rd_count_q, rd_count_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic [1:0]            occ;
    logic [1:0]            fill;
    logic [1:0]            occ_nxt;
    logic [1:0]            fill_nxt;
    logic                  xfer;
    logic                  rd_room;

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push_vld (inflight_q),
        .push_dat (fifo_data_out),
        .pop_rdy  (out_ready),
        .head_dat (out_data),
        .occ      (occ)
    );

    assign fill = occ + {1'b0, inflight_q};
    assign xfer = out_valid && out_ready;
    // A slot freed by this cycle's delivery may be refilled at once; that keeps one word per cycle.
    assign rd_room = (fill < DEPTH_L) || ((fill == DEPTH_L) && xfer);
    assign occ_nxt  = occ + {1'b0, inflight_q} - {1'b0, xfer};
    assign fill_nxt = occ_nxt + {1'b0, fifo_read};

    always_comb begin
        fifo_read = enable && !fifo_empty && !rst && rd_room;
        out_valid = (occ != 2'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fifo_read) state_d = STREAM;
            end
            STREAM: begin
                if ((fill_nxt == DEPTH_L) && !xfer)
                    state_d = STALL;
                else if ((occ == 2'd0) && !inflight_q && !fifo_read)
                    state_d = IDLE;
            end
            STALL: begin
                if (xfer) state_d = STREAM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = fifo_read;
        rd_count_d = rd_count_q;
        checksum_d = checksum_q;
        if (xfer) begin
            rd_count_d = rd_count_q + CNT_W'(1);
            checksum_d = checksum_q ^ out_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            rd_count_q <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
            checksum_q <= checksum_d;
        end
    end

    assign rd_count = rd_count_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboarded bench for fifo_reader: a behavioural source FIFO feeds the DUT and delivered words must
// leave in write order, minus any words the DUT had already pulled when reset hit.
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_read;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   rd_count;
    logic [DW-1:0] checksum;

    fifo_reader #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rd_count      (rd_count),
        .checksum      (checksum)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [15:0]   exp_cnt = '0;
    logic [DW-1:0] exp_chk = '0;
    int            cyc = 0;
    int            rd_issued = 0;
    int            delivered = 0;
    int            first_rd_cyc = -1;
    int            first_vld_cyc = -1;
    int            deliv_cyc[$];
    logic          read_pend = 1'b0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic          wrap_preset = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source FIFO: a read strobed in a cycle pops at the closing edge and the word is held on fifo_data_out.
    always @(posedge clk) begin
        logic [DW-1:0] w;
        cyc++;
        if (read_pend && src_q.size() > 0) begin
            w = src_q.pop_front();
            fifo_data_out <= w;
        end
        fifo_empty <= (src_q.size() == 0);
    end

    always @(negedge clk) begin
        logic [DW-1:0] e;
        read_pend = fifo_read && !rst;
        if (wrap_preset) exp_cnt = 16'hFFFE;
        if (rst) begin
            check("rst_ctl", {30'd0, fifo_read, out_valid}, 32'd0);
            check("rst_dat", {out_data, rd_count, checksum}, 32'd0);
            // Words already pulled from the source are lost; only those still queued may appear later.
            while (exp_q.size() > src_q.size()) void'(exp_q.pop_front());
            exp_cnt   = '0;
            exp_chk   = '0;
            prev_hold = 1'b0;
        end else begin
            check("read_gate", {31'd0, fifo_read && fifo_empty}, 32'd0);
            if (fifo_read) begin
                rd_issued++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (prev_hold) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {24'd0, out_data}, {24'd0, prev_dat});
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e});
                    check("rd_count", {16'd0, rd_count}, {16'd0, exp_cnt});
                    check("checksum", {24'd0, checksum}, {24'd0, exp_chk});
                    exp_cnt = exp_cnt + 16'd1;
                    exp_chk = exp_chk ^ e;
                end
                delivered++;
                deliv_cyc.push_back(cyc);
            end
            prev_hold = out_valid && !out_ready;
            prev_dat  = out_data;
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (n < max && !(exp_q.size() == 0 && src_q.size() == 0 && !out_valid)) begin
            step(1);
            n++;
        end
        step(2);
        check({name, "_drain_timeout"}, {31'd0, n < max}, 32'd1);
    endtask

    initial begin
        int rd_base;
        int dl_base;
        int span;
        rst       = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;

        // Reset with a non-empty source and reads enabled, then stream four words.
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        step(3);
        rst = 1'b0;
        wait_idle(100, "stream");
        check("s_delivered", delivered, 4);
        span = (deliv_cyc.size() == 4) ? deliv_cyc[3] - deliv_cyc[0] : -1;
        check("s_consecutive", span, 3);
        check("s_latency", first_vld_cyc - first_rd_cyc, 2);
        check("s_rd_count", {16'd0, rd_count}, 32'h4);
        check("s_checksum", {24'd0, checksum}, 32'h44);

        // Backpressure: only two reads fit, head word held.
        out_ready = 1'b0;
        rd_base   = rd_issued;
        dl_base   = delivered;
        push_word(8'hA1); push_word(8'hA2); push_word(8'hA3); push_word(8'hA4);
        step(6);
        check("bp_reads", rd_issued - rd_base, 2);
        check("bp_state", 32'(dut.state_q), 32'(STALL));
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head", {24'd0, out_data}, 32'hA1);
        out_ready = 1'b1;
        wait_idle(100, "bp");
        check("bp_delivered", delivered - dl_base, 4);
        check("bp_rd_count", {16'd0, rd_count}, 32'h8);

        // Empty guard, then a single word.
        rd_base = rd_issued;
        dl_base = delivered;
        step(10);
        check("eg_reads", rd_issued - rd_base, 0);
        check("eg_state", 32'(dut.state_q), 32'(IDLE));
        push_word(8'h5A);
        wait_idle(100, "eg");
        check("eg_reads_one", rd_issued - rd_base, 1);
        check("eg_delivered", delivered - dl_base, 1);

        // Reset while the buffer is full: buffered words vanish, the rest of the source still arrives.
        out_ready = 1'b0;
        push_word(8'h61); push_word(8'h62); push_word(8'h63); push_word(8'h64); push_word(8'h65);
        step(5);
        check("mr_full", {30'd0, dut.occ}, 32'd2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_counters", {8'd0, rd_count, checksum}, 32'd0);
        dl_base   = delivered;
        out_ready = 1'b1;
        wait_idle(100, "mr");
        check("mr_delivered", delivered - dl_base, 3);
        check("mr_rd_count", {16'd0, rd_count}, 32'h3);

        // Counter wrap.
        force dut.rd_count_q = 16'hFFFE;
        wrap_preset = 1'b1;
        step(1);
        release dut.rd_count_q;
        wrap_preset = 1'b0;
        check("wrap_start", {16'd0, rd_count}, 32'hFFFE);
        push_word(8'h01); push_word(8'h02); push_word(8'h03);
        wait_idle(100, "wrap");
        check("wrap_end", {16'd0, rd_count}, 32'h0001);

        // Random enable, backpressure and source traffic.
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) != 0) push_word(8'($urandom_range(0, 255)));
            step(1);
        end
        enable    = 1'b1;
        out_ready = 1'b1;
        wait_idle(2000, "rand");
        check("rand_rd_count", {16'd0, rd_count}, {16'd0, exp_cnt});
        check("rand_checksum", {24'd0, checksum}, {24'd0, exp_chk});
        check("rand_state", 32'(dut.state_q), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
